can_rx_deserializer: RTL and testbench

- Serial receive companion to the team's bit-serial CAN-style transmitter.
- Recovers LSB-first 8-bit frames from the `can_rx` line: idle recessive 1, one dominant start bit 0, data bits, optional even-parity bit, recessive stop bit 1.
- Samples at mid-bit using a clock-count bit timer and presents each byte on a valid/ack holding register.
- Sits between the bus pin and the host-side controller logic.

---
 rtl/can_pkg.sv | 18 +
 rtl/can_bit_timer.sv | 25 ++
 rtl/can_rx_deserializer.sv | 176 +++++++++++++++++
 tb/tb_can_rx_deserializer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN serial definitions: receiver state encoding and the bus idle level.
// Defining CAN_RX_PARITY_EN adds the PARITY receive state.
package can_pkg;

  localparam logic CAN_RECESSIVE = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef CAN_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_IDLE
  } can_rx_state_t;

endpackage

// File: rtl/can_bit_timer.sv
// Loadable bit-time down-counter; expire is high while the count sits at zero.
module can_bit_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/can_rx_deserializer.sv
// Mid-bit sampling CAN-style byte receiver with valid/ack holding register.
// Define CAN_RX_PARITY_EN to receive and check an even-parity bit before the stop bit.
module can_rx_deserializer
  import can_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              can_rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);

  can_rx_state_t     state, state_next;
  logic              rx_meta, rx_s, rx_prev;
  logic [1:0]        sync_fill;
  logic              t_load, expire;
  logic [TW-1:0]     t_val;
  logic              shift_en, stop_smp, good;
  logic [IW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              par_bad;
`ifdef CAN_RX_PARITY_EN
  logic              par_smp;
`endif

  // rx_prev stays 0 until the sync flops hold real line samples, so a line
  // that is already low out of reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= CAN_RECESSIVE;
      rx_s      <= CAN_RECESSIVE;
      sync_fill <= '0;
      rx_prev   <= 1'b0;
    end else begin
      rx_meta   <= can_rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= sync_fill[1] & rx_s;
    end
  end

  can_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    t_load     = 1'b0;
    t_val      = FULL_LOAD;
    shift_en   = 1'b0;
    stop_smp   = 1'b0;
`ifdef CAN_RX_PARITY_EN
    par_smp    = 1'b0;
`endif
    unique case (state)
      RX_IDLE:
        if (rx_prev && !rx_s) begin
          t_load     = 1'b1;
          t_val      = HALF_LOAD;
          state_next = RX_START;
        end
      RX_START:
        if (expire) begin
          if (rx_s == CAN_RECESSIVE) begin
            state_next = RX_IDLE;
          end else begin
            t_load     = 1'b1;
            state_next = RX_DATA;
          end
        end
      RX_DATA:
        if (expire) begin
          shift_en = 1'b1;
          t_load   = 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef CAN_RX_PARITY_EN
            state_next = RX_PARITY;
`else
            state_next = RX_STOP;
`endif
          end
        end
`ifdef CAN_RX_PARITY_EN
      RX_PARITY:
        if (expire) begin
          par_smp    = 1'b1;
          t_load     = 1'b1;
          state_next = RX_STOP;
        end
`endif
      RX_STOP:
        if (expire) begin
          stop_smp   = 1'b1;
          state_next = (rx_s == CAN_RECESSIVE) ? RX_IDLE : RX_WAIT_IDLE;
        end
      RX_WAIT_IDLE:
        if (rx_s == CAN_RECESSIVE) state_next = RX_IDLE;
      default:
        state_next = RX_IDLE;
    endcase
  end

  // Right-shift LSB-first: after DATA_W samples bit i lands at position i.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == RX_START && t_load) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      bit_idx <= bit_idx + IW'(1);
      shreg   <= {rx_s, shreg[DATA_W-1:1]};
    end
  end

`ifdef CAN_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_smp) par_bad <= (^shreg) ^ rx_s;
      parity_err <= stop_smp & rx_s & par_bad;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign good = stop_smp & rx_s & ~par_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= stop_smp & ~rx_s;
      overrun_err <= good & data_valid & ~data_ack;
      if (good && (!data_valid || data_ack)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

// File: tb/tb_can_rx_deserializer.sv
// Self-checking bench for can_rx_deserializer (CLKS_PER_BIT=4, DATA_W=8).
// Build with CAN_RX_PARITY_EN defined on both bench and RTL to exercise parity.
module tb_can_rx_deserializer;

  localparam int C = 4;
`ifdef CAN_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 3 + C / 2 + (8 + 1 + PB) * C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       can_rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, rx_busy, frame_err, parity_err, overrun_err;

  can_rx_deserializer #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .can_rx      (can_rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_fe;
  } vec_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  logic dv_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Advance to the next falling edge and observe outputs there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (frame_err)   fe_cnt++;
    if (parity_err)  pe_cnt++;
    if (overrun_err) ov_cnt++;
    if (data_valid && !dv_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("sb_data", 32'(data_out), 32'(e.data));
        check("sb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    dv_prev = data_valid;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip,
                            input logic push);
    if (push) sb.push_back('{data: d, cyc: cyc + LAT});
    can_rx = 1'b0;
    repeat (C) tick();
    for (int i = 0; i < 8; i++) begin
      can_rx = d[i];
      repeat (C) tick();
    end
    if (PB != 0) begin
      can_rx = (^d) ^ par_flip;
      repeat (C) tick();
    end
    can_rx = stop;
    repeat (C) tick();
  endtask

  task automatic ack_and_check(input string name);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check(name, 32'(data_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   n;
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_fe: 1'b1};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_fe: 1'b0};

    // Reset state, with the line held low to prove it is not a start edge.
    can_rx = 1'b0;
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_errs", 32'({frame_err, parity_err, overrun_err}), 32'd0);
    reset = 1'b0;
    repeat (30) tick();
    check("low_line_no_start", 32'(rx_busy), 32'd0);
    can_rx = 1'b1;
    repeat (4) tick();

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      fe_cnt = 0;
      send_frame(vecs[v].data, vecs[v].stop, 1'b0, !vecs[v].exp_fe);
      if (vecs[v].exp_fe) begin
        repeat (20) tick();
        check("wait_idle_hold", 32'(rx_busy), 32'd1);
        can_rx = 1'b1;
        repeat (4) tick();
        check("wait_idle_exit", 32'(rx_busy), 32'd0);
      end else begin
        repeat (3) tick();
        check("vec_data_out", 32'(data_out), 32'(vecs[v].data));
      end
      check("vec_frame_err", 32'(fe_cnt), 32'(vecs[v].exp_fe));
      check("vec_valid", 32'(data_valid), 32'(!vecs[v].exp_fe));
      if (data_valid) ack_and_check("vec_ack_clear");
    end

    // Short low glitch on an idle line.
    fe_cnt = 0;
    n = cyc;
    can_rx = 1'b0;
    repeat (2) tick();
    can_rx = 1'b1;
    tick();
    check("glitch_busy_rise", 32'(rx_busy), 32'd1);
    repeat (2) tick();
    check("glitch_cycle", 32'(cyc), 32'(n + 5));
    check("glitch_busy_fall", 32'(rx_busy), 32'd0);
    repeat (10) tick();
    check("glitch_no_valid", 32'(data_valid), 32'd0);
    check("glitch_no_err", 32'(fe_cnt + pe_cnt + ov_cnt), 32'd0);

    // Back-to-back without ack: second frame overruns.
    ov_cnt = 0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("ovr_count", 32'(ov_cnt), 32'd1);
    check("ovr_keep_old", 32'(data_out), 32'h11);
    check("ovr_valid", 32'(data_valid), 32'd1);
    ack_and_check("ovr_ack_clear");

    // Ack landing on the second completion cycle: new byte loads, no overrun.
    ov_cnt = 0;
    send_frame(8'h11, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    check("ack_same_data", 32'(data_out), 32'h22);
    check("ack_same_valid", 32'(data_valid), 32'd1);
    repeat (3) tick();
    check("ack_same_no_ovr", 32'(ov_cnt), 32'd0);

`ifdef CAN_RX_PARITY_EN
    ack_and_check("par_pre_clear");
    pe_cnt = 0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("par_err_count", 32'(pe_cnt), 32'd1);
    check("par_err_no_valid", 32'(data_valid), 32'd0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    check("par_ok_data", 32'(data_out), 32'h07);
    check("par_ok_count", 32'(pe_cnt), 32'd1);
`endif

    // Reset after data bit 3 of 0xFF with a byte still held.
    check("pre_reset_valid", 32'(data_valid), 32'd1);
    can_rx = 1'b0;
    repeat (C) tick();
    can_rx = 1'b1;
    repeat (4 * C) tick();
    check("mid_frame_busy", 32'(rx_busy), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_data_out", 32'(data_out), 32'd0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_busy", 32'(rx_busy), 32'd0);
    check("mid_rst_errs", 32'({frame_err, parity_err, overrun_err}), 32'd0);
    reset = 1'b0;
    fe_cnt = 0;
    repeat (4) tick();
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (3) tick();
    check("post_rst_data", 32'(data_out), 32'h5A);
    check("post_rst_no_fe", 32'(fe_cnt), 32'd0);
    ack_and_check("post_rst_ack");

`ifndef CAN_RX_PARITY_EN
    check("parity_tied_off", 32'(pe_cnt), 32'd0);
`endif
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
